// File: rtl/approx_eval_pkg.sv
// Shared types and arithmetic helpers for the approximate-circuit error scanner.
package approx_eval_pkg;

    localparam int DEF_OP_W  = 2;
    localparam int DEF_OUT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

    function automatic logic [31:0] exact_madd(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] c);
        return a * b + c;
    endfunction

    function automatic logic [31:0] abs_diff(input logic [31:0] x,
                                             input logic [31:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/madd_exact_ref.sv
// Purpose: exact a*b+c truncated to OUT_W bits, golden reference for the scanner.
// Latency: purely combinational, zero cycles.
// Backpressure: none, output follows inputs continuously.
module madd_exact_ref
    import approx_eval_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [OP_W-1:0]  c,
    output logic [OUT_W-1:0] y
);

    assign y = OUT_W'(exact_madd(32'(a), 32'(b), 32'(c)));

endmodule

// File: rtl/approx_error_scanner.sv
// Purpose: sweeps every vector through an approximate circuit and accumulates error stats vs exact a*b+c.
// Latency: start to done is 2^IN_W + 2 cycles; EARLY_ABORT_EN cuts the sweep at the first error above ET.
// Backpressure: none; start is ignored while busy, results hold until the next accepted start.
module approx_error_scanner
    import approx_eval_pkg::*;
#(
    parameter int OP_W  = DEF_OP_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int ET    = 3,
    parameter int IN_W  = 3 * OP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [IN_W-1:0]       stim,
    input  logic [OUT_W-1:0]      approx_out,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W:0]         err_cnt,
    output logic [IN_W+OUT_W-1:0] err_sum,
    output logic [IN_W-1:0]       first_fail,
    output logic                  pass
`ifdef EARLY_ABORT_EN
    ,
    output logic                  aborted
`endif
);

    localparam logic [OUT_W-1:0] ET_V = OUT_W'(ET);

    scan_state_t      state;
    logic [IN_W-1:0]  smp_idx;
    logic [OUT_W-1:0] smp_approx;
    logic             smp_vld;
    logic             ff_vld;
    logic [OUT_W-1:0] smp_exact;
    logic [OUT_W-1:0] smp_err;
    logic             acc_en;

    // Response is captured one cycle after its vector is driven; the error is
    // evaluated from the captured copy so the exact path never sees stim directly.
    madd_exact_ref #(
        .OP_W  (OP_W),
        .OUT_W (OUT_W)
    ) u_exact (
        .a (smp_idx[OP_W-1:0]),
        .b (smp_idx[2*OP_W-1:OP_W]),
        .c (smp_idx[3*OP_W-1:2*OP_W]),
        .y (smp_exact)
    );

    assign smp_err = OUT_W'(abs_diff(32'(smp_exact), 32'(smp_approx)));
    assign acc_en  = smp_vld && ((state == SCAN) || (state == DRAIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            max_err    <= '0;
            err_cnt    <= '0;
            err_sum    <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            smp_idx    <= '0;
            smp_approx <= '0;
            smp_vld    <= 1'b0;
            ff_vld     <= 1'b0;
`ifdef EARLY_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            if (acc_en) begin
                if (smp_err > max_err)
                    max_err <= smp_err;
                if (smp_err != '0) begin
                    err_cnt <= err_cnt + (IN_W+1)'(1);
                    err_sum <= err_sum + (IN_W+OUT_W)'(smp_err);
                    if (!ff_vld) begin
                        first_fail <= smp_idx;
                        ff_vld     <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SCAN;
                        busy       <= 1'b1;
                        stim       <= '0;
                        max_err    <= '0;
                        err_cnt    <= '0;
                        err_sum    <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        smp_vld    <= 1'b0;
                        ff_vld     <= 1'b0;
`ifdef EARLY_ABORT_EN
                        aborted    <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    smp_approx <= approx_out;
                    smp_idx    <= stim;
                    smp_vld    <= 1'b1;
                    stim       <= stim + IN_W'(1);
                    if (stim == '1)
                        state <= DRAIN;
                end
                DRAIN: begin
                    smp_vld <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (max_err <= ET_V);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef EARLY_ABORT_EN
            // Any sample above threshold ends the sweep; the vector already in flight is dropped.
            if (acc_en && (smp_err > ET_V)) begin
                state   <= DONE;
                smp_vld <= 1'b0;
                stim    <= '0;
                aborted <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_approx_error_scanner.sv
// Randomised scoreboard bench for approx_error_scanner; honours EARLY_ABORT_EN when defined.
module tb_approx_error_scanner;

    localparam int OP_W  = 2;
    localparam int OUT_W = 4;
    localparam int IN_W  = 3 * OP_W;
    localparam int ET    = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [IN_W-1:0]       stim;
    logic [OUT_W-1:0]      approx_out;
    logic                  busy;
    logic                  done;
    logic [OUT_W-1:0]      max_err;
    logic [IN_W:0]         err_cnt;
    logic [IN_W+OUT_W-1:0] err_sum;
    logic [IN_W-1:0]       first_fail;
    logic                  pass;
`ifdef EARLY_ABORT_EN
    logic                  aborted;
`endif

    always #5 clk = ~clk;

    approx_error_scanner #(
        .OP_W  (OP_W),
        .OUT_W (OUT_W),
        .ET    (ET)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stim       (stim),
        .approx_out (approx_out),
        .busy       (busy),
        .done       (done),
        .max_err    (max_err),
        .err_cnt    (err_cnt),
        .err_sum    (err_sum),
        .first_fail (first_fail),
        .pass       (pass)
`ifdef EARLY_ABORT_EN
        ,
        .aborted    (aborted)
`endif
    );

    // Circuit under evaluation, selected by mode.
    logic [OUT_W-1:0] cut_exact;
    int               mode;
    logic [OUT_W-1:0] lut [64];

    madd_exact_ref #(.OP_W(OP_W), .OUT_W(OUT_W)) u_cut (
        .a (stim[1:0]),
        .b (stim[3:2]),
        .c (stim[5:4]),
        .y (cut_exact)
    );

    always_comb begin
        approx_out = cut_exact;
        case (mode)
            1:       approx_out = '0;
            2:       approx_out = cut_exact + 4'd1;
            3:       approx_out = lut[stim];
            default: approx_out = cut_exact;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mx;
        int cnt;
        int sum;
        int ff;
        int ps;
        int ab;
        int lat;
        int t0;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int exact_of(input int v);
        return (v % 4) * ((v / 4) % 4) + (v / 16);
    endfunction

    function automatic int approx_of(input int v);
        case (mode)
            1:       return 0;
            2:       return (exact_of(v) + 1) % 16;
            3:       return int'(lut[v]);
            default: return exact_of(v);
        endcase
    endfunction

    // Whole-sweep statistics straight from the definition.
    function automatic exp_t model(input int t0);
        exp_t r;
        int   e;
        int   last;
        r = '{mx: 0, cnt: 0, sum: 0, ff: -1, ps: 0, ab: 0, lat: 0, t0: t0};
        last = 63;
        for (int v = 0; v < 64; v++) begin
            e = exact_of(v) - approx_of(v);
            if (e < 0) e = -e;
            if (e > r.mx) r.mx = e;
            if (e != 0) begin
                r.cnt++;
                r.sum += e;
                if (r.ff < 0) r.ff = v;
            end
`ifdef EARLY_ABORT_EN
            if (e > ET) begin
                r.ab = 1;
                last = v;
                break;
            end
`endif
        end
        if (r.ff < 0) r.ff = 0;
        r.ps  = (r.mx <= ET) ? 1 : 0;
        r.lat = last + 3;
        return r;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency",    cyc - e.t0 - 1, e.lat);
                chk("max_err",    int'(max_err),    e.mx);
                chk("err_cnt",    int'(err_cnt),    e.cnt);
                chk("err_sum",    int'(err_sum),    e.sum);
                chk("first_fail", int'(first_fail), e.ff);
                chk("pass",       int'(pass),       e.ps);
                chk("busy_at_done", int'(busy),     0);
`ifdef EARLY_ABORT_EN
                chk("aborted",    int'(aborted),    e.ab);
`endif
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            chk(name, q.size(), 0);
            q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_scan(input int m, input bit restart);
        mode = m;
        @(negedge clk);
        q.push_back(model(cyc));
        pulse_start();
        repeat (4) @(negedge clk);
        chk("busy_mid_scan", int'(busy), 1);
        if (restart) begin
            repeat (4) @(negedge clk);
            pulse_start();
        end
        wait_empty("done_timeout");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_done"},       int'(done),       0);
        chk({tag, "_stim"},       int'(stim),       0);
        chk({tag, "_max_err"},    int'(max_err),    0);
        chk({tag, "_err_cnt"},    int'(err_cnt),    0);
        chk({tag, "_err_sum"},    int'(err_sum),    0);
        chk({tag, "_first_fail"}, int'(first_fail), 0);
        chk({tag, "_pass"},       int'(pass),       0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        foreach (lut[i]) lut[i] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_scan(0, 1'b0);
        run_scan(1, 1'b0);
        run_scan(2, 1'b0);
        run_scan(0, 1'b1);

        // Reset during a scan: no done must follow, then a clean scan.
        mode = 1;
        @(negedge clk);
        pulse_start();
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_rst");
        rst = 1'b0;
        repeat (80) @(negedge clk);
        run_scan(0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 64; v++)
                lut[v] = ($urandom_range(0, 1) == 1) ? 4'(exact_of(v))
                                                      : 4'($urandom_range(0, 15));
            run_scan(3, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_error_scanner.md
Name: approx_error_scanner

Overview:
- Sequential evaluator for approximated combinational circuits. It sweeps every input vector through the circuit under evaluation and compares each response against the exact multiply-add.
- Reports max absolute error, erroneous-vector count, summed absolute error, first failing vector, and pass/fail against the error threshold.
- Sits on the evaluation side of an approximated netlist: it drives the netlist's inputs and consumes its outputs.

Parameters:
- OP_W, 2, width of each operand a, b, c.
- IN_W, 3*OP_W (6), stimulus width; vector = {c, b, a}, a in the LSBs.
- OUT_W, 4, result width of the exact and approximate outputs.
- ET, 3, error threshold; pass iff max_err <= ET.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins a scan when idle.
- stim  out  IN_W  registered vector driven to the circuit under evaluation.
- approx_out  in  OUT_W  combinational response of the circuit to stim.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- max_err  out  OUT_W  largest |exact - approx| seen.
- err_cnt  out  IN_W+1  number of vectors with nonzero error.
- err_sum  out  IN_W+OUT_W  sum of absolute errors.
- first_fail  out  IN_W  lowest vector index with nonzero error; 0 if none.
- pass  out  1  max_err <= ET; valid when done is pulsed and held until next start.

Behaviour:
- Reset: all outputs 0, state IDLE, stim 0.
- Exact function: exact = a*b + c, computed at OUT_W bits.
- OP_W=2 gives a maximum of 12, so no overflow occurs at the defaults.
- Error: error = |exact - approx_out|, computed on unsigned OUT_W values with no wrap.
- FSM states:
  - IDLE: start -> SCAN. Clear all accumulators, clear the first_fail-valid flag, stim=0, busy=1.
  - SCAN: each cycle, sample approx_out for the stim driven in the previous cycle, then advance stim by 1.
  - After the last vector (all ones) is driven -> DRAIN.
  - DRAIN: sample the final vector -> DONE.
  - DONE: pulse done for 1 cycle, compute pass, busy=0 -> IDLE.
- Latency: start to done is 2^IN_W + 2 cycles (66 at defaults).
- Sampling: the first sample uses stim=0. The sampled index is tracked in a one-cycle-delayed register matching stim.
- Accumulation per sample:
  - if error > max_err, update max_err;
  - if error != 0, increment err_cnt and add error to err_sum;
  - if error != 0 and no failure recorded yet, set first_fail = index and set the flag.
- Results hold their values after done until the next accepted start.
- start while busy: ignored.
- rst mid-scan: immediate return to IDLE with all outputs 0; no done pulse.
- stim wraps to 0 after the final vector; the scan does not restart.

Optional Feature:
- Macro: EARLY_ABORT_EN.
- Defined:
  - an extra output aborted (1 bit) is present;
  - the first sampled error > ET goes directly to DONE, with pass=0 and aborted=1;
  - accumulators reflect only the vectors up to and including the failing one.
- Undefined:
  - there is no aborted port;
  - the full sweep always runs.

Decomposition:
- Shared package approx_eval_pkg:
  - state enum (IDLE, SCAN, DRAIN, DONE);
  - OP_W/OUT_W defaults;
  - exact_madd function (a*b+c);
  - abs_diff function.
- One sub-module: madd_exact_ref.
  - Purely combinational exact a*b+c.
  - Reused as a golden model and by the bench.

Test Plan:
- Exact circuit as the circuit under evaluation (approx_out = madd_exact_ref(stim)), start -> done at cycle 66; max_err=0, err_cnt=0, err_sum=0, first_fail=0, pass=1.
- approx_out stuck at 0 -> max_err=12, err_cnt=57, err_sum=240, first_fail=5, pass=0.
- approx_out = exact+1 -> max_err=1, err_cnt=64, err_sum=64, first_fail=0, pass=1.
- rst asserted at cycle 20 of a scan -> next cycle all outputs 0, no done. A fresh start then completes normally with exact-circuit results.
- start pulsed again at cycle 10 while busy -> ignored; a single done arrives at cycle 66.
- EARLY_ABORT_EN defined, stuck-at-0 circuit -> abort at vector 10 (a=2, b=2, error 4); done, aborted=1, pass=0, max_err=4, first_fail=5.
